lvt_regfile_mw_mr: RTL and testbench

- Parametrised multi-write, multi-read register file built on a Live Value Table (LVT).
- One storage bank per write port. The LVT records, per address, which bank holds the most recent value.
- Read ports select the live bank through the LVT, giving a fully general NUM_WRITE-to-1 word select per read port.
- Sits in the core as the general-purpose register file serving decode operand reads and writeback/load-return writes.

---
 rtl/lvt_regfile_mw_mr.sv | 105 ++++++++++
 tb/tb_lvt_regfile_mw_mr.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lvt_regfile_mw_mr.sv
// Multi-write, multi-read register file: one bank per write port, with a Live Value
// Table that records which bank holds the newest copy of each address.
module lvt_regfile_mw_mr #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_WRITE  = 2,
  parameter int NUM_READ   = 4,
  parameter int BYPASS     = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [NUM_WRITE-1:0]             we_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  waddr_i,
  input  logic [NUM_WRITE*WORD_WIDTH-1:0]  wdata_i,
  input  logic [NUM_READ-1:0]              re_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr_i,
  output logic [NUM_READ*WORD_WIDTH-1:0]   rdata_o,
  output logic [NUM_READ-1:0]              rvalid_o,
  output logic                             wr_conflict_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LVT_W = (NUM_WRITE > 2) ? $clog2(NUM_WRITE) : 1;

  if (NUM_WRITE < 2 || NUM_WRITE > 4) begin : g_bad_num_write
    $error("lvt_regfile_mw_mr: NUM_WRITE must be in 2..4");
  end
  if (NUM_READ < 1 || NUM_READ > 8) begin : g_bad_num_read
    $error("lvt_regfile_mw_mr: NUM_READ must be in 1..8");
  end

  logic [ADDR_WIDTH-1:0] waddr [NUM_WRITE];
  logic [WORD_WIDTH-1:0] wdata [NUM_WRITE];
  logic [ADDR_WIDTH-1:0] raddr [NUM_READ];

  for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wunpack
    assign waddr[k] = waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata[k] = wdata_i[k*WORD_WIDTH +: WORD_WIDTH];
  end
  for (genvar j = 0; j < NUM_READ; j++) begin : g_runpack
    assign raddr[j] = raddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [WORD_WIDTH-1:0]          bank_q [NUM_WRITE][DEPTH];
  logic [WORD_WIDTH-1:0]          bank_d [NUM_WRITE][DEPTH];
  logic [LVT_W-1:0]               lvt_q  [DEPTH];
  logic [LVT_W-1:0]               lvt_d  [DEPTH];
  logic [NUM_READ*WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_READ-1:0]            rvalid_q, rvalid_d;
  logic                           wr_conflict_q, wr_conflict_d;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latches are inferred.
    bank_d        = bank_q;
    lvt_d         = lvt_q;
    rdata_d       = rdata_q;
    rvalid_d      = re_i;
    wr_conflict_d = 1'b0;

    // Ascending port order lets the highest enabled port win the LVT entry on a collision.
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (we_i[k]) begin
        bank_d[k][waddr[k]] = wdata[k];
        lvt_d[waddr[k]]     = LVT_W'(k);
      end
    end

    for (int i = 0; i < NUM_WRITE; i++) begin
      for (int k = i + 1; k < NUM_WRITE; k++) begin
        if (we_i[i] && we_i[k] && (waddr[i] == waddr[k])) wr_conflict_d = 1'b1;
      end
    end

    // Reading the next-state view forwards the winning write data in the same cycle.
    for (int j = 0; j < NUM_READ; j++) begin
      if (re_i[j]) begin
        if (BYPASS != 0) rdata_d[j*WORD_WIDTH +: WORD_WIDTH] = bank_d[lvt_d[raddr[j]]][raddr[j]];
        else             rdata_d[j*WORD_WIDTH +: WORD_WIDTH] = bank_q[lvt_q[raddr[j]]][raddr[j]];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: banks and LVT are reset because the architectural register state after reset is zero.
      bank_q        <= '{default: '0};
      lvt_q         <= '{default: '0};
      rdata_q       <= '0;
      rvalid_q      <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      bank_q        <= bank_d;
      lvt_q         <= lvt_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign rdata_o       = rdata_q;
  assign rvalid_o      = rvalid_q;
  assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_lvt_regfile_mw_mr.sv
// Bench for lvt_regfile_mw_mr: directed vector table on a 2W/4R bypassing instance,
// hand sequences for no-bypass and mid-stream reset, and a 3W/4R random soak.
module tb_lvt_regfile_mw_mr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 2 write / 4 read instances sharing stimulus, one with and one without bypass.
  logic [1:0]   we;
  logic [7:0]   waddr;
  logic [63:0]  wdata;
  logic [3:0]   re;
  logic [15:0]  raddr;
  logic [127:0] rdata, rdata_nb;
  logic [3:0]   rvalid, rvalid_nb;
  logic         conf, conf_nb;

  // 3 write / 4 read soak instance.
  logic [2:0]   s_we;
  logic [11:0]  s_waddr;
  logic [95:0]  s_wdata;
  logic [3:0]   s_re;
  logic [15:0]  s_raddr;
  logic [127:0] s_rdata;
  logic [3:0]   s_rvalid;
  logic         s_conf;

  lvt_regfile_mw_mr #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .NUM_WRITE(2), .NUM_READ(4), .BYPASS(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid), .wr_conflict_o(conf));

  lvt_regfile_mw_mr #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .NUM_WRITE(2), .NUM_READ(4), .BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_nb), .rvalid_o(rvalid_nb), .wr_conflict_o(conf_nb));

  lvt_regfile_mw_mr #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .NUM_WRITE(3), .NUM_READ(4), .BYPASS(1)) dut_soak (
    .clk_i(clk), .rst_n_i(rst_n), .we_i(s_we), .waddr_i(s_waddr), .wdata_i(s_wdata),
    .re_i(s_re), .raddr_i(s_raddr), .rdata_o(s_rdata), .rvalid_o(s_rvalid), .wr_conflict_o(s_conf));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   we;
    logic [7:0]   waddr;     // {port1, port0}
    logic [63:0]  wdata;     // {port1, port0}
    logic [3:0]   re;
    logic [15:0]  raddr;     // {port3, port2, port1, port0}
    logic [3:0]   exp_rvalid;
    logic [3:0]   chk_rd;    // ports whose rdata is compared
    logic [127:0] exp_rdata; // {port3, port2, port1, port0}
    logic         exp_conf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] w_en, input logic [7:0] w_a, input logic [63:0] w_d,
                              input logic [3:0] r_en, input logic [15:0] r_a, input logic [3:0] e_rv,
                              input logic [3:0] e_chk, input logic [127:0] e_rd, input logic e_cf);
    vec_t v;
    v.we = w_en; v.waddr = w_a; v.wdata = w_d; v.re = r_en; v.raddr = r_a;
    v.exp_rvalid = e_rv; v.chk_rd = e_chk; v.exp_rdata = e_rd; v.exp_conf = e_cf;
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mem [16];
  logic [31:0] exp_rd [4];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    s_we = '0; s_waddr = '0; s_wdata = '0; s_re = '0; s_raddr = '0;

    // Reset state.
    step(); step();
    check("reset_rdata", rdata, '0);
    check("reset_rvalid", {124'd0, rvalid}, '0);
    check("reset_conf", {127'd0, conf}, '0);
    check("reset_soak_rdata", s_rdata, '0);
    rst_n = 1'b1;

    // Every port sweeps all 16 addresses after reset.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a0;
      a0 = 4'(i);
      add(2'b00, 8'h00, 64'h0, 4'hF, {a0 + 4'd12, a0 + 4'd8, a0 + 4'd4, a0},
          4'hF, 4'hF, 128'h0, 1'b0);
    end
    add(2'b01, 8'h03, {32'h0, 32'hDEADBEEF}, 4'h0, 16'h0, 4'h0, 4'h0, 128'h0, 1'b0);
    add(2'b10, 8'h30, {32'h12345678, 32'h0}, 4'h0, 16'h0, 4'h0, 4'h0, 128'h0, 1'b0);
    add(2'b00, 8'h00, 64'h0, 4'hF, 16'h3333, 4'hF, 4'hF, {4{32'h12345678}}, 1'b0);
    add(2'b01, 8'h03, {32'h0, 32'hCAFEF00D}, 4'h0, 16'h0, 4'h0, 4'hF, {4{32'h12345678}}, 1'b0);
    add(2'b00, 8'h00, 64'h0, 4'hF, 16'h3333, 4'hF, 4'hF, {4{32'hCAFEF00D}}, 1'b0);
    add(2'b11, 8'h77, {32'h22222222, 32'h11111111}, 4'h0, 16'h0, 4'h0, 4'hF, {4{32'hCAFEF00D}}, 1'b1);
    add(2'b00, 8'h00, 64'h0, 4'h0, 16'h0, 4'h0, 4'h0, 128'h0, 1'b0);
    add(2'b00, 8'h00, 64'h0, 4'hF, 16'h7777, 4'hF, 4'hF, {4{32'h22222222}}, 1'b0);
    add(2'b01, 8'h05, {32'h0, 32'hA5A5A5A5}, 4'h1, 16'h0005, 4'h1, 4'hF,
        {32'h22222222, 32'h22222222, 32'h22222222, 32'hA5A5A5A5}, 1'b0);
    add(2'b11, 8'h99, {32'hBBBB0002, 32'hAAAA0001}, 4'h2, 16'h0090, 4'h2, 4'hF,
        {32'h22222222, 32'h22222222, 32'hBBBB0002, 32'hA5A5A5A5}, 1'b1);
    add(2'b10, 8'h00, {32'h00000F0F, 32'h0}, 4'hC, 16'h9000, 4'hC, 4'hF,
        {32'hBBBB0002, 32'h00000F0F, 32'hBBBB0002, 32'hA5A5A5A5}, 1'b0);
    add(2'b00, 8'h00, 64'h0, 4'hF, 16'h0573, 4'hF, 4'hF,
        {32'h00000F0F, 32'hA5A5A5A5, 32'h22222222, 32'hCAFEF00D}, 1'b0);
    add(2'b11, 8'h64, {32'h66666666, 32'h44444444}, 4'h0, 16'h0, 4'h0, 4'h0, 128'h0, 1'b0);
    add(2'b00, 8'h00, 64'h0, 4'hF, 16'h4646, 4'hF, 4'hF,
        {32'h44444444, 32'h66666666, 32'h44444444, 32'h66666666}, 1'b0);
    add(2'b01, 8'h11, {32'hFFFFFFFF, 32'h01010101}, 4'h0, 16'h0, 4'h0, 4'h0, 128'h0, 1'b0);
    add(2'b00, 8'h00, 64'h0, 4'h1, 16'h0001, 4'h1, 4'hF,
        {32'h44444444, 32'h66666666, 32'h44444444, 32'h01010101}, 1'b0);

    foreach (vecs[n]) begin
      we = vecs[n].we; waddr = vecs[n].waddr; wdata = vecs[n].wdata;
      re = vecs[n].re; raddr = vecs[n].raddr;
      step();
      check($sformatf("vec%0d_rvalid", n), {124'd0, rvalid}, {124'd0, vecs[n].exp_rvalid});
      check($sformatf("vec%0d_conf", n), {127'd0, conf}, {127'd0, vecs[n].exp_conf});
      for (int j = 0; j < 4; j++) begin
        if (vecs[n].chk_rd[j])
          check($sformatf("vec%0d_rdata%0d", n, j), {96'd0, rdata[j*32 +: 32]},
                {96'd0, vecs[n].exp_rdata[j*32 +: 32]});
      end
    end

    // Read-during-write: bypass instance forwards, non-bypass returns the old value.
    idle_inputs();
    we = 2'b01; waddr = 8'h0B; wdata = {32'h0, 32'h5A5A5A5A}; re = 4'h1; raddr = 16'h000B;
    step();
    check("rdw_bypass", {96'd0, rdata[31:0]}, {96'd0, 32'h5A5A5A5A});
    check("rdw_nobypass", {96'd0, rdata_nb[31:0]}, 128'h0);
    check("rdw_nobypass_rvalid", {127'd0, rvalid_nb[0]}, 128'h1);
    idle_inputs();
    re = 4'h1; raddr = 16'h000B;
    step();
    check("rdw_nobypass_after", {96'd0, rdata_nb[31:0]}, {96'd0, 32'h5A5A5A5A});

    // Reset asserted mid-stream discards the in-flight read and clears the array.
    idle_inputs();
    we = 2'b10; waddr = 8'h20; wdata = {32'h55AA55AA, 32'h0};
    step();
    idle_inputs();
    re = 4'h4; raddr = 16'h0200;
    step();
    check("pre_reset_read", {96'd0, rdata[95:64]}, {96'd0, 32'h55AA55AA});
    rst_n = 1'b0;
    we = 2'b11; waddr = 8'h22; wdata = {32'h77777777, 32'h88888888}; re = 4'hF; raddr = 16'h2222;
    step();
    check("mid_reset_rdata", rdata, '0);
    check("mid_reset_rvalid", {124'd0, rvalid}, '0);
    check("mid_reset_conf", {127'd0, conf}, '0);
    rst_n = 1'b1;
    idle_inputs();
    re = 4'hF; raddr = 16'h2222;
    step();
    check("post_reset_rdata", rdata, '0);
    check("post_reset_rvalid", {124'd0, rvalid}, 128'hF);
    check("post_reset_conf", {127'd0, conf}, '0);
    idle_inputs();

    // Random soak on the 3-write instance against a flat highest-index-wins model.
    for (int a = 0; a < 16; a++) mem[a] = '0;
    for (int j = 0; j < 4; j++) exp_rd[j] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [31:0] nmem [16];
      logic        e_conf;
      s_we = 3'($urandom_range(0, 7));
      s_re = 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) begin
        s_waddr[k*4 +: 4]  = 4'($urandom_range(0, 15));
        s_wdata[k*32 +: 32] = $urandom;
      end
      for (int j = 0; j < 4; j++) s_raddr[j*4 +: 4] = 4'($urandom_range(0, 15));
      nmem = mem;
      for (int k = 0; k < 3; k++) if (s_we[k]) nmem[s_waddr[k*4 +: 4]] = s_wdata[k*32 +: 32];
      e_conf = 1'b0;
      for (int p = 0; p < 3; p++)
        for (int q = p + 1; q < 3; q++)
          if (s_we[p] && s_we[q] && s_waddr[p*4 +: 4] == s_waddr[q*4 +: 4]) e_conf = 1'b1;
      for (int j = 0; j < 4; j++) if (s_re[j]) exp_rd[j] = nmem[s_raddr[j*4 +: 4]];
      mem = nmem;
      step();
      check($sformatf("soak%0d_rvalid", cyc), {124'd0, s_rvalid}, {124'd0, s_re});
      check($sformatf("soak%0d_conf", cyc), {127'd0, s_conf}, {127'd0, e_conf});
      check($sformatf("soak%0d_rdata", cyc), s_rdata, {exp_rd[3], exp_rd[2], exp_rd[1], exp_rd[0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
